// File: rtl/reg_bus_master.sv
// Register-bus initiator: serialises host commands into single-cycle bus strobes and
// autonomously polls the latched-alarm register, writing observed alarm bits back to clear them.
module reg_bus_master #(
    parameter logic [15:0] POLL_ADDR    = 16'h0000,
    parameter int          POLL_PERIOD  = 100000,
    parameter int          READ_LATENCY = 1,
    parameter int          CNT_W        = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        read_en,
    output logic        write_en,
    output logic [15:0] addr,
    output logic [15:0] data_out,
    input  logic [15:0] data_in,
    input  logic        poll_enable,
    output logic        alarm_event,
    output logic [11:0] alarm_bits
);

    localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0]  TIMER_LAST = CNT_W'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE, CRD, CWAIT, CRSP, CWR, PRD, PWAIT, PCLR
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic              poll_due_q, poll_due_d;

    logic        read_en_q, read_en_d;
    logic        write_en_q, write_en_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_out_q, data_out_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        alarm_event_q, alarm_event_d;
    logic [11:0] alarm_bits_q, alarm_bits_d;

    logic cmd_take;
    logic poll_start;
    logic wait_done;
    logic alarm_nz;

    // A command offered in IDLE always wins; a due poll only goes out on a command-free IDLE cycle.
    assign cmd_ready  = (state_q == IDLE) && !rst;
    assign cmd_take   = (state_q == IDLE) && cmd_valid;
    assign poll_start = (state_q == IDLE) && !cmd_valid && poll_due_q;
    assign wait_done  = (wait_q == WAIT_LAST);
    assign alarm_nz   = |data_in[11:0];

    // A wrap that coincides with a poll start re-arms poll_due, so at most one poll is ever owed.
    always_comb begin
        timer_d    = timer_q;
        poll_due_d = poll_due_q;
        if (!poll_enable) begin
            timer_d    = '0;
            poll_due_d = 1'b0;
        end else begin
            if (timer_q == TIMER_LAST) begin
                timer_d    = '0;
                poll_due_d = 1'b1;
            end else begin
                timer_d = timer_q + CNT_W'(1);
                if (poll_start) begin
                    poll_due_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            timer_q    <= '0;
            poll_due_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            timer_q    <= timer_d;
            poll_due_q <= poll_due_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (cmd_take) begin
                    state_d = cmd_write ? CWR : CRD;
                end else if (poll_start) begin
                    state_d = PRD;
                end
            end
            CRD:   state_d = CWAIT;
            CWAIT: begin
                if (wait_done) begin
                    state_d = CRSP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            CRSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            CWR:   state_d = IDLE;
            PRD:   state_d = PWAIT;
            PWAIT: begin
                if (wait_done) begin
                    state_d = alarm_nz ? PCLR : IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            PCLR:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes default low each cycle; bus address/data and the response hold until overwritten.
    always_comb begin
        read_en_d     = 1'b0;
        write_en_d    = 1'b0;
        alarm_event_d = 1'b0;
        addr_d        = addr_q;
        data_out_d    = data_out_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        alarm_bits_d  = alarm_bits_q;
        case (state_q)
            IDLE: begin
                if (cmd_take) begin
                    addr_d     = cmd_addr;
                    read_en_d  = !cmd_write;
                    write_en_d = cmd_write;
                    if (cmd_write) begin
                        data_out_d = cmd_wdata;
                    end
                end else if (poll_start) begin
                    addr_d    = POLL_ADDR;
                    read_en_d = 1'b1;
                end
            end
            CWAIT: begin
                if (wait_done) begin
                    rsp_data_d  = data_in;
                    rsp_valid_d = 1'b1;
                end
            end
            CRSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
            PWAIT: begin
                if (wait_done && alarm_nz) begin
                    alarm_bits_d  = data_in[11:0];
                    alarm_event_d = 1'b1;
                    addr_d        = POLL_ADDR;
                    data_out_d    = {4'b0000, data_in[11:0]};
                    write_en_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_en_q     <= 1'b0;
            write_en_q    <= 1'b0;
            addr_q        <= '0;
            data_out_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            alarm_event_q <= 1'b0;
            alarm_bits_q  <= '0;
        end else begin
            read_en_q     <= read_en_d;
            write_en_q    <= write_en_d;
            addr_q        <= addr_d;
            data_out_q    <= data_out_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            alarm_event_q <= alarm_event_d;
            alarm_bits_q  <= alarm_bits_d;
        end
    end

    assign read_en     = read_en_q;
    assign write_en    = write_en_q;
    assign addr        = addr_q;
    assign data_out    = data_out_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign alarm_event = alarm_event_q;
    assign alarm_bits  = alarm_bits_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// Bench for reg_bus_master: a behavioural slave (RAM plus write-1-to-clear alarm register),
// directed timing checks, then random commands against a shadow-memory reference.
module tb_reg_bus_master;

    localparam int          PERIOD = 16;
    localparam logic [15:0] PADDR  = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        read_en;
    logic        write_en;
    logic [15:0] addr;
    logic [15:0] data_out;
    logic [15:0] data_in = 16'h0;
    logic        poll_enable;
    logic        alarm_event;
    logic [11:0] alarm_bits;

    reg_bus_master #(
        .POLL_ADDR(PADDR), .POLL_PERIOD(PERIOD), .READ_LATENCY(1), .CNT_W(5)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .read_en(read_en), .write_en(write_en), .addr(addr),
        .data_out(data_out), .data_in(data_in),
        .poll_enable(poll_enable), .alarm_event(alarm_event), .alarm_bits(alarm_bits)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [11:0] bits;
        logic [15:0] dout;
        logic [15:0] a;
        logic        we;
    } ev_t;

    logic [15:0] mem [16] = '{default: 16'h0};
    logic [11:0] alarmReg   = 12'h0;
    logic [11:0] injectBits = 12'h0;
    int          injectSeq  = 0;
    int          seenSeq    = 0;
    logic        pendValid  = 1'b0;
    logic [15:0] pendData   = 16'h0;
    int          overlapCount = 0;
    ev_t         evRec;
    ev_t         evQ[$];

    // Alarm reads carry a nonzero upper nibble that polling must ignore.
    function automatic logic [15:0] slaveRead(input logic [15:0] a);
        if (a == PADDR) return {4'hC, alarmReg};
        if (a[15:4] == 12'h0) return mem[a[3:0]];
        return 16'h0;
    endfunction

    // Slave data appears the cycle after read_en; updates happen mid-cycle, away from the DUT edge.
    always @(negedge clk) begin
        if (injectSeq != seenSeq) begin
            alarmReg = alarmReg | injectBits;
            seenSeq  = injectSeq;
        end
        data_in   = pendValid ? pendData : 16'h0;
        pendValid = read_en;
        pendData  = slaveRead(addr);
        if (write_en) begin
            if (addr == PADDR) alarmReg = alarmReg & ~data_out[11:0];
            else if (addr[15:4] == 12'h0) mem[addr[3:0]] = data_out;
        end
        if (read_en && write_en) overlapCount++;
        if (alarm_event) begin
            evRec.bits = alarm_bits;
            evRec.dout = data_out;
            evRec.a    = addr;
            evRec.we   = write_en;
            evQ.push_back(evRec);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offers one command and returns in the cycle after it was accepted.
    task automatic applyStimulus(input logic wr, input logic [15:0] a, input logic [15:0] wd);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        for (int n = 0; n < 60; n++) begin
            if (cmd_ready) break;
            tick();
        end
        checkOutput("cmdAccepted", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic waitPoll(output int n);
        n = 0;
        while (n < 64) begin
            tick();
            n++;
            if (read_en) break;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          n;
        int          cnt;
        int          evCnt;
        int          evStart;
        logic        wr;
        logic        got;
        logic [15:0] a;
        logic [15:0] wd;
        logic [15:0] expData;
        logic [11:0] refInjected;
        logic [11:0] evOr;
        logic [15:0] refMem [16];

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0;
        cmd_wdata = 16'h0; rsp_ready = 1'b0; poll_enable = 1'b0;
        for (int i = 0; i < 16; i++) refMem[i] = 16'h0;
        tick();
        tick();
        $display("[TB] reset state");
        checkOutput("rstCmdReady", 32'(cmd_ready), 32'd0);
        checkOutput("rstStrobes", 32'({read_en, write_en, rsp_valid, alarm_event}), 32'd0);
        checkOutput("rstBusRegs", {addr, data_out}, 32'd0);
        checkOutput("rstRspRegs", 32'({rsp_data, alarm_bits}), 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("idleCmdReady", 32'(cmd_ready), 32'd1);

        applyStimulus(1'b1, 16'h0005, 16'h1234);
        refMem[5] = 16'h1234;
        tick();

        $display("[TB] command read");
        rsp_ready = 1'b1;
        applyStimulus(1'b0, 16'h0005, 16'h0);
        checkOutput("rdStrobe", 32'({read_en, write_en, cmd_ready}), 32'b100);
        checkOutput("rdAddr", 32'(addr), 32'h0005);
        tick();
        checkOutput("rdPulseEnds", 32'({read_en, rsp_valid}), 32'd0);
        tick();
        checkOutput("rdRspValid", 32'(rsp_valid), 32'd1);
        checkOutput("rdRspData", 32'(rsp_data), 32'h1234);
        tick();
        checkOutput("rdRspDone", 32'({rsp_valid, cmd_ready}), 32'b01);

        $display("[TB] response backpressure");
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 16'h0005, 16'h0);
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("bpHold", 32'({rsp_valid, cmd_ready, rsp_data}), 32'({1'b1, 1'b0, 16'h1234}));
        end
        rsp_ready = 1'b1;
        tick();
        checkOutput("bpRelease", 32'({rsp_valid, cmd_ready}), 32'b01);
        rsp_ready = 1'b0;

        $display("[TB] command write");
        applyStimulus(1'b1, 16'h0000, 16'h0FFF);
        checkOutput("wrStrobe", 32'({write_en, read_en}), 32'b10);
        checkOutput("wrBus", {addr, data_out}, 32'h0000_0FFF);
        tick();
        checkOutput("wrDone", 32'({write_en, rsp_valid, cmd_ready}), 32'b001);

        $display("[TB] poll with alarms");
        injectBits = 12'h081;
        injectSeq++;
        poll_enable = 1'b1;
        waitPoll(n);
        checkOutput("pollFirstDelay", 32'(n), 32'(PERIOD + 1));
        checkOutput("pollAddr", 32'(addr), 32'(PADDR));
        tick();
        tick();
        checkOutput("pollEvent", 32'({alarm_event, write_en, alarm_bits}), 32'({2'b11, 12'h081}));
        checkOutput("pollClearBus", {addr, data_out}, {PADDR, 16'h0081});
        tick();
        checkOutput("pollEventEnds", 32'({alarm_event, write_en, alarm_bits}), 32'({2'b00, 12'h081}));
        waitPoll(n);
        checkOutput("pollSecondDelay", 32'(n), 32'(PERIOD - 3));
        tick();
        tick();
        checkOutput("pollQuiet", 32'({alarm_event, cmd_ready}), 32'b01);
        poll_enable = 1'b0;
        tick();

        $display("[TB] command and poll collision");
        poll_enable = 1'b1;
        rsp_ready = 1'b1;
        repeat (PERIOD) tick();
        applyStimulus(1'b0, 16'h0005, 16'h0);
        checkOutput("colCmdFirst", 32'({read_en, addr}), 32'({1'b1, 16'h0005}));
        tick();
        tick();
        checkOutput("colRsp", 32'({rsp_valid, rsp_data}), 32'({1'b1, 16'h1234}));
        tick();
        tick();
        checkOutput("colPollNext", 32'({read_en, addr}), 32'({1'b1, PADDR}));
        cnt = 0;
        evCnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (read_en) cnt++;
            if (alarm_event) evCnt++;
        end
        checkOutput("colSinglePoll", 32'(cnt), 32'd0);
        checkOutput("colNoEvent", 32'(evCnt), 32'd0);
        waitPoll(n);
        checkOutput("colNextPoll", 32'(n), 32'd2);
        poll_enable = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) tick();

        $display("[TB] reset mid-transaction");
        poll_enable = 1'b1;
        repeat (5) tick();
        applyStimulus(1'b0, 16'h0005, 16'h0);
        tick();
        tick();
        checkOutput("rstMidCrsp", 32'(rsp_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstAsync", 32'({rsp_valid, read_en, write_en, alarm_event, cmd_ready}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rstRspDropped", 32'(rsp_valid), 32'd0);
        waitPoll(n);
        checkOutput("rstPollDelay", 32'(n), 32'(PERIOD + 1));
        tick();
        tick();

        $display("[TB] random commands with background polling");
        evStart = evQ.size();
        refInjected = 12'h0;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                injectBits = 12'($urandom_range(1, 4095));
                injectSeq++;
                refInjected = refInjected | injectBits;
            end
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) a = 16'h0100 | 16'($urandom_range(0, 255));
            else a = 16'($urandom_range(1, 15));
            wd = 16'($urandom);
            applyStimulus(wr, a, wd);
            if (wr) begin
                if (a[15:4] == 12'h0) refMem[a[3:0]] = wd;
                tick();
                checkOutput("rndWrNoRsp", 32'(rsp_valid), 32'd0);
            end else begin
                expData = (a[15:4] == 12'h0) ? refMem[a[3:0]] : 16'h0;
                got = 1'b0;
                for (int c = 0; c < 30 && !got; c++) begin
                    rsp_ready = 1'($urandom_range(0, 1));
                    if (rsp_valid && rsp_ready) begin
                        checkOutput("rndRspData", 32'(rsp_data), 32'(expData));
                        got = 1'b1;
                    end
                    tick();
                end
                rsp_ready = 1'b0;
                checkOutput("rndRspSeen", 32'(got), 32'd1);
            end
            repeat ($urandom_range(0, 3)) tick();
        end
        repeat (3 * PERIOD) tick();
        poll_enable = 1'b0;
        repeat (3) tick();

        evOr = 12'h0;
        for (int i = evStart; i < evQ.size(); i++) begin
            checkOutput("rndEvClear", 32'({evQ[i].we, evQ[i].a, evQ[i].dout[15:12]}), 32'({1'b1, PADDR, 4'h0}));
            checkOutput("rndEvData", 32'(evQ[i].dout[11:0]), 32'(evQ[i].bits));
            evOr = evOr | evQ[i].bits;
        end
        checkOutput("rndAlarmsReported", 32'(evOr), 32'(refInjected));
        checkOutput("rndAlarmsCleared", 32'(alarmReg), 32'd0);
        checkOutput("noStrobeOverlap", 32'(overlapCount), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
